// File: rtl/gray_counter_conv.sv
// rtl/gray_counter_conv.sv - up/down counter holding binary and reflected-Gray count, loadable from Gray
//
// Purpose:
//   Keeps a WIDTH-bit binary count and its reflected-Gray image in registers.
//   It can be resumed from a Gray-coded value, which is converted to binary
//   internally by a prefix XOR. It counts up or down with modular wrap, and it
//   flags each wrap-around with a registered one-cycle pulse.
//
// Parameters:
//   WIDTH     counter width in bits (>= 2)
//   INIT      binary count loaded at reset (< 2**WIDTH)
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst_n     synchronous active-low reset, overrides load and en
//   en        count enable
//   up        direction when counting: 1 = increment, 0 = decrement
//   load      load request, has priority over en
//   load_gray Gray-coded load value
//   bin       registered binary count
//   gray      registered Gray count, always bin ^ (bin >> 1)
//   wrap      registered one-cycle pulse when the count wraps around

module gray_counter_conv #(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT ^ (INIT >> 1);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it,
  // built as a running prefix from the MSB down.
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] step_bin;
  logic             step_wrap;

  // Counting step. The Gray value is always derived from the new binary count,
  // so consecutive counts differ in one Gray bit even across a direction change.
  always_comb begin
    step_bin  = up ? (bin_q + ONE) : (bin_q - ONE);
    step_wrap = up ? (&bin_q) : ~(|bin_q);
  end

  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    wrap_d = 1'b0;
    if (load) begin
      // The loaded Gray value is stored as given; only the binary side is derived.
      bin_d  = g2b(load_gray);
      gray_d = load_gray;
    end else if (en) begin
      bin_d  = step_bin;
      gray_d = b2g(step_bin);
      wrap_d = step_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= INIT;
      gray_q <= INIT_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter_conv.sv
// tb/tb_gray_counter_conv.sv - scoreboard bench for gray_counter_conv at WIDTH 4 and WIDTH 8

module tb_gray_counter_conv;

  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] gray;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b0, en4 = 1'b0, up4 = 1'b0, load4 = 1'b0;
  logic [3:0] lg4  = '0;
  logic [3:0] bin4, gray4;
  logic       wrap4;

  logic       rst8 = 1'b0, en8 = 1'b0, up8 = 1'b0, load8 = 1'b0;
  logic [7:0] lg8  = '0;
  logic [7:0] bin8, gray8;
  logic       wrap8;

  gray_counter_conv #(.WIDTH(4), .INIT(4'h0)) dut4 (
    .clk(clk), .rst_n(rst4), .en(en4), .up(up4), .load(load4),
    .load_gray(lg4), .bin(bin4), .gray(gray4), .wrap(wrap4)
  );

  gray_counter_conv #(.WIDTH(8), .INIT(8'hFE)) dut8 (
    .clk(clk), .rst_n(rst8), .en(en8), .up(up8), .load(load8),
    .load_gray(lg8), .bin(bin8), .gray(gray8), .wrap(wrap8)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q4[$];
  exp_t q8[$];
  exp_t m4, m8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: Gray to binary as XOR of all Gray bits at or above each position.
  function automatic exp_t model(input int w, input exp_t cur, input logic r, input logic e,
                                 input logic u, input logic l, input logic [7:0] lg,
                                 input logic [7:0] init);
    exp_t       n;
    logic [7:0] mask;
    logic [7:0] g;
    mask   = 8'((1 << w) - 1);
    g      = lg & mask;
    n      = cur;
    n.wrap = 1'b0;
    if (!r) begin
      n.bin = init;
    end else if (l) begin
      n.bin = '0;
      for (int i = 0; i < w; i++) n.bin[i] = ^(g >> i);
    end else if (e) begin
      n.bin  = (u ? cur.bin + 8'd1 : cur.bin - 8'd1) & mask;
      n.wrap = u ? (cur.bin == mask) : (cur.bin == 8'd0);
    end
    n.gray = (r && l) ? g : (n.bin ^ (n.bin >> 1));
    return n;
  endfunction

  task automatic step4(input logic r, input logic e, input logic u, input logic l, input logic [3:0] lg);
    exp_t x;
    @(negedge clk);
    rst4 = r; en4 = e; up4 = u; load4 = l; lg4 = lg;
    rst8 = 1'b1; en8 = 1'b0; load8 = 1'b0;
    m4 = model(4, m4, r, e, u, l, {4'h0, lg}, 8'h00);
    q4.push_back(m4);
    @(posedge clk);
    #1;
    x = q4.pop_front();
    check("bin4",  {28'd0, bin4},  {24'd0, x.bin});
    check("gray4", {28'd0, gray4}, {24'd0, x.gray});
    check("wrap4", {31'd0, wrap4}, {31'd0, x.wrap});
  endtask

  task automatic step8(input logic r, input logic e, input logic u, input logic l, input logic [7:0] lg);
    exp_t x;
    @(negedge clk);
    rst8 = r; en8 = e; up8 = u; load8 = l; lg8 = lg;
    rst4 = 1'b1; en4 = 1'b0; load4 = 1'b0;
    m8 = model(8, m8, r, e, u, l, lg, 8'hFE);
    q8.push_back(m8);
    @(posedge clk);
    #1;
    x = q8.pop_front();
    check("bin8",  {24'd0, bin8},  {24'd0, x.bin});
    check("gray8", {24'd0, gray8}, {24'd0, x.gray});
    check("wrap8", {31'd0, wrap8}, {31'd0, x.wrap});
  endtask

  logic [3:0] up_seq [16];
  logic [7:0] prev_gray;
  logic       re, ru, rl;
  logic [7:0] rlg;

  initial begin
    up_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    m4 = '0;
    m8 = '0;

    // WIDTH=4: reset then full count-up cycle with wrap back to 0
    step4(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step4(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    check("rst_gray4", {28'd0, gray4}, 32'h0);
    check("rst_wrap4", {31'd0, wrap4}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      check("up_seq_gray", {28'd0, gray4}, {28'd0, up_seq[i]});
      check("up_seq_wrap", {31'd0, wrap4}, (i == 15) ? 32'd1 : 32'd0);
    end

    // Load conversion, then one increment
    step4(1'b1, 1'b0, 1'b0, 1'b1, 4'hD);
    check("load_bin", {28'd0, bin4}, 32'h9);
    check("load_gray", {28'd0, gray4}, 32'hD);
    step4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    check("load_inc_bin", {28'd0, bin4}, 32'hA);
    check("load_inc_gray", {28'd0, gray4}, 32'hF);

    // Down wrap from 0
    step4(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    step4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    check("dn_wrap_bin", {28'd0, bin4}, 32'hF);
    check("dn_wrap_gray", {28'd0, gray4}, 32'h8);
    check("dn_wrap_pulse", {31'd0, wrap4}, 32'h1);
    step4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    check("dn_next_bin", {28'd0, bin4}, 32'hE);
    check("dn_next_gray", {28'd0, gray4}, 32'h9);
    check("dn_next_wrap", {31'd0, wrap4}, 32'h0);

    // Load beats enable, then hold
    step4(1'b1, 1'b1, 1'b1, 1'b1, 4'h6);
    check("prio_bin", {28'd0, bin4}, 32'h4);
    check("prio_gray", {28'd0, gray4}, 32'h6);
    for (int i = 0; i < 3; i++) begin
      step4(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      check("hold_bin", {28'd0, bin4}, 32'h4);
      check("hold_wrap", {31'd0, wrap4}, 32'h0);
    end

    // Reset coincident with load and enable while bin=7
    step4(1'b1, 1'b0, 1'b0, 1'b1, 4'h4);
    check("pre_rst_bin", {28'd0, bin4}, 32'h7);
    step4(1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    check("mid_rst_bin", {28'd0, bin4}, 32'h0);
    check("mid_rst_gray", {28'd0, gray4}, 32'h0);

    // Direction changes without a bubble
    for (int i = 0; i < 40; i++) begin
      step4(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'h0);
    end

    // WIDTH=8, INIT=FE
    step8(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step8(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst8_gray", {24'd0, gray8}, 32'h81);
    step8(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("w8_ff_bin", {24'd0, bin8}, 32'hFF);
    check("w8_ff_gray", {24'd0, gray8}, 32'h80);
    check("w8_ff_wrap", {31'd0, wrap8}, 32'h0);
    step8(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("w8_00_bin", {24'd0, bin8}, 32'h00);
    check("w8_00_gray", {24'd0, gray8}, 32'h00);
    check("w8_00_wrap", {31'd0, wrap8}, 32'h1);

    // Random en/up with occasional loads; invariants on every cycle
    for (int i = 0; i < 1000; i++) begin
      prev_gray = gray8;
      re  = 1'($urandom_range(0, 3) != 0);
      ru  = 1'($urandom_range(0, 1));
      rl  = 1'($urandom_range(0, 31) == 0);
      rlg = 8'($urandom_range(0, 255));
      step8(1'b1, re, ru, rl, rlg);
      check("inv_gray", {24'd0, gray8}, {24'd0, bin8 ^ (bin8 >> 1)});
      if (re && !rl) check("gray_1bit", $countones(gray8 ^ prev_gray), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_counter_conv.md
Name: gray_counter_conv

Overview:
- Parametrised up/down counter that keeps a binary count and its reflected-Gray equivalent in registers.
- Generalises the combinational 4-bit Gray-to-binary converter:
  - arbitrary WIDTH;
  - loadable from a Gray-coded value, converted to binary internally by prefix XOR;
  - up/down counting with wrap detection;
  - registered outputs.
- Used as a pointer or position counter wherever a Gray-coded value must be produced or resumed from, e.g. encoder position tracking or async-FIFO pointers.

Parameters:
- WIDTH, 4: counter width in bits. Must be >= 2.
- INIT, 0: binary count value loaded at reset. Must be < 2**WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when counting.
- load  input  1  load request. Has priority over en.
- load_gray  input  WIDTH  Gray-coded load value.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray count. Always equal to bin ^ (bin >> 1).
- wrap  output  1  registered one-cycle pulse on counter wrap-around.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. rst_n is sampled only on the rising edge of clk.
- Reset (rst_n=0 at an edge), which overrides load and en:
  - bin <= INIT;
  - gray <= INIT ^ (INIT >> 1);
  - wrap <= 0.
  - Reset asserted mid-count or coincident with load discards that operation.
- Priority at each edge with rst_n=1: load, then en, then hold.
- Load (load=1):
  - bin <= G2B(load_gray), where b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i] for i from WIDTH-2 down to 0;
  - gray <= load_gray unchanged;
  - wrap <= 0.
  - en and up are ignored in that cycle.
- Count (load=0, en=1):
  - up=1: bin <= (bin + 1) mod 2**WIDTH.
  - up=0: bin <= (bin - 1) mod 2**WIDTH.
  - gray <= next_bin ^ (next_bin >> 1), computed from the next value, never from the old gray.
  - wrap <= 1 iff (up=1 and bin = all-ones) or (up=0 and bin = 0). Otherwise wrap <= 0.
- Hold (load=0, en=0): bin and gray keep their values; wrap <= 0.
- Latency:
  - Outputs update one edge after inputs are sampled. bin, gray and wrap change on the same edge.
  - wrap is high for exactly the one cycle in which the wrapped value is presented.
- Invariants:
  - gray == bin ^ (bin >> 1) in every cycle after reset.
  - While counting, successive gray values differ in exactly one bit. This includes across the wrap and across direction changes.
  - A load may change any number of bits.
- Direction changes between consecutive enabled cycles take effect immediately; no turnaround bubble.
- All arithmetic is unsigned, WIDTH bits, with natural modular wrap. No saturation.
- No X propagation: every register is assigned on every clock edge path.

Test Plan:
- Reset and count up (WIDTH=4, INIT=0): hold rst_n=0 for 2 cycles, release, set en=1, up=1.
  - Required gray sequence: 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0.
  - wrap=1 only in the cycle gray returns to 0 (bin F->0).
- Load conversion: load=1, load_gray=4'b1101 for one cycle.
  - Required next cycle: bin=4'b1001 (9), gray=4'b1101, wrap=0.
  - Then en=1, up=1 gives bin=A, gray=F.
- Down wrap: from bin=0, set en=1, up=0.
  - Required: bin=F, gray=8, wrap=1 for one cycle.
  - Next cycle: bin=E, gray=9, wrap=0.
- Priority and hold:
  - load=1 with en=1, up=1, load_gray=0110: required bin=4, gray=6, no increment.
  - Then en=0 for 3 cycles: outputs hold, wrap=0.
- Reset mid-operation: rst_n=0 at an edge while bin=7, en=1, load=1.
  - Required next cycle: bin=INIT, gray=INIT^(INIT>>1), wrap=0.
- WIDTH=8, INIT=8'hFE:
  - After reset, gray=8'h81.
  - Count up 2 cycles: bin=FF, gray=80, wrap=0; then bin=00, gray=00, wrap=1.
  - Checker asserts single-bit Gray change on every count and gray==bin^(bin>>1) throughout 1000 random en/up cycles.
